// File: rtl/key_inv_ex.sv
// Iterative inverse AES-128 key scheduler: optional forward pre-pass to
// round 10, then streams round keys 10..0 under a valid/ready handshake.
module key_inv_ex #(
    parameter int NR     = 10,
    parameter bit FWD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st,
    input  logic         mode,
    input  logic [127:0] k_i,
    input  logic         rk_rdy,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx,
    output logic         rk_vld,
    output logic         busy,
    output logic         done
);

    // state  | meaning
    // S_IDLE | waiting for st; k_i/mode captured on the st cycle
    // S_FWD  | forward pre-pass, counter walks 1..NR
    // S_OUT  | presenting round key [counter], inverse step on each transfer
    // S_DONE | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_FWD, S_OUT, S_DONE} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // entry 0 sits in the top byte, so index from the MSB end
        sbox = SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     cnt_q, cnt_d;

    logic [31:0]    k0, k1, k2, k3;
    logic [31:0]    sub_in, rot, g_out;
    logic [127:0]   fwd_key, inv_key;

    assign {k0, k1, k2, k3} = key_q;

    // Single SubWord instance: forward feeds W3, inverse feeds W7^W6
    assign sub_in = (state_q == S_FWD) ? k3 : (k3 ^ k2);
    assign rot    = {sub_in[23:0], sub_in[31:24]};
    assign g_out  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                    ^ {rcon(cnt_q), 24'h0};

    always_comb begin
        logic [31:0] n0, n1, n2;
        n0      = k0 ^ g_out;
        n1      = n0 ^ k1;
        n2      = n1 ^ k2;
        fwd_key = {n0, n1, n2, n2 ^ k3};
        inv_key = {k0 ^ g_out, k1 ^ k0, k2 ^ k1, k3 ^ k2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (st) begin
                    key_d = k_i;
                    if (mode && FWD_EN) begin
                        cnt_d   = 4'd1;
                        state_d = S_FWD;
                    end else begin
                        cnt_d   = LAST;
                        state_d = S_OUT;
                    end
                end
            end
            S_FWD: begin
                key_d = fwd_key;
                if (cnt_q == LAST) state_d = S_OUT;
                else               cnt_d   = cnt_q + 4'd1;
            end
            S_OUT: begin
                if (rk_rdy) begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        key_d = inv_key;
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rk_o   = key_q;
    assign rk_idx = cnt_q;
    assign rk_vld = (state_q == S_OUT);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_key_inv_ex.sv
// Self-checking bench for key_inv_ex: directed sweeps with random keys and
// backpressure, compared against a word-level FIPS-197 key expansion model.
module tb_key_inv_ex;

    logic         clk;
    logic         rst_n;
    logic         st;
    logic         mode;
    logic [127:0] k_i;
    logic         rk_rdy;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx;
    logic         rk_vld;
    logic         busy;
    logic         done;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_exp [11];

    key_inv_ex #(.NR(10), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .st(st), .mode(mode), .k_i(k_i),
        .rk_rdy(rk_rdy), .rk_o(rk_o), .rk_idx(rk_idx), .rk_vld(rk_vld),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xtime(aa);
        end
        gmul = r;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = key;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        rand128 = {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rk_o"}, rk_o, 128'h0);
        chk({tag, "_flags"}, 128'({rk_idx, rk_vld, busy, done}), 128'h0);
    endtask

    // Starts at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic sweep(input bit m, input logic [127:0] key_in, input int lat_exp,
                         input bit bp, input bit glitch, input int abort_idx, input bit chain);
        int lat = 1;
        int idx = 10;
        int cyc = 0;
        st = 1'b1; mode = m; k_i = key_in;
        @(posedge clk); @(negedge clk);
        st = 1'b0; mode = 1'($urandom); k_i = rand128();
        chk("busy_after_start", 128'(busy), 128'h1);
        while (!rk_vld && lat < 40) begin
            if (glitch && lat == 3) begin st = 1'b1; k_i = rand128(); mode = 1'b0; end
            else st = 1'b0;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        st = 1'b0;
        chk("first_valid_latency", 128'(lat), 128'(lat_exp));
        while (idx >= 0 && cyc < 200) begin
            chk("rk_idx", 128'(rk_idx), 128'(idx));
            chk("rk_o", rk_o, rk_exp[idx]);
            chk("rk_vld_in_out", 128'({rk_vld, done}), 128'h2);
            if (idx == abort_idx) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("async_reset");
                @(negedge clk);
                chk_zero("held_reset");
                rst_n = 1'b1; rk_rdy = 1'b0;
                @(negedge clk);
                chk_zero("after_reset_release");
                return;
            end
            if (glitch && idx == 6) begin st = 1'b1; k_i = rand128(); mode = 1'b1; end
            else st = 1'b0;
            rk_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); @(negedge clk);
            cyc++;
            if (rk_rdy) idx--;
        end
        st = 1'b0;
        chk("sweep_completed", 128'(idx), 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
        chk("done_pulse", 128'({done, rk_vld, busy}), 128'h5);
        if (chain) begin st = 1'b1; k_i = rand128(); mode = 1'b0; end
        rk_rdy = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        chk("idle_after_done", 128'({done, rk_vld, busy}), 128'h0);
    endtask

    initial begin
        logic [127:0] key;
        int           m;
        rst_n = 1'b0; st = 1'b0; mode = 1'b0; k_i = '0; rk_rdy = 1'b0;
        build_sbox();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");

        // FIPS-197 cipher key through the forward pre-pass
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("model_round10", rk_exp[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_round9", rk_exp[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("model_round1", rk_exp[1], 128'ha0fafe1788542cb123a339392a6c7605);
        sweep(1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 11, 1'b0, 1'b0, -1, 1'b0);
        sweep(1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 1'b0, 1'b0, -1, 1'b0);

        // backpressure in both modes
        key = rand128(); expand(key);
        sweep(1'b0, rk_exp[10], 1, 1'b1, 1'b0, -1, 1'b0);
        key = rand128(); expand(key);
        sweep(1'b1, key, 11, 1'b1, 1'b0, -1, 1'b0);

        // st pulses during FWD and OUT must be ignored
        key = rand128(); expand(key);
        sweep(1'b1, key, 11, 1'b0, 1'b1, -1, 1'b0);

        // reset at index 5, then a clean run
        key = rand128(); expand(key);
        sweep(1'b1, key, 11, 1'b0, 1'b0, 5, 1'b0);
        sweep(1'b1, key, 11, 1'b0, 1'b0, -1, 1'b0);

        // back-to-back runs; st raised during DONE with a junk key
        key = rand128(); expand(key);
        sweep(1'b1, key, 11, 1'b0, 1'b0, -1, 1'b1);
        key = rand128(); expand(key);
        sweep(1'b0, rk_exp[10], 1, 1'b1, 1'b0, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            key = rand128(); expand(key);
            m = int'($urandom_range(0, 1));
            if (m == 1) sweep(1'b1, key, 11, 1'b1, 1'b0, -1, 1'b0);
            else        sweep(1'b0, rk_exp[10], 1, 1'b1, 1'b0, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/key_inv_ex.md
Name: key_inv_ex

Overview:
- Iterative inverse AES-128 key scheduler for the decryption datapath.
- Accepts either the cipher key (round-0 key) or the final round key (round 10), then streams the round keys in reverse order (10 down to 0), one per accepted transfer.
- Optional forward pre-pass derives the round-10 key when given the cipher key.
- Sits between key load and the inverse-cipher round engine.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128.
- FWD_EN, 1, 1 = forward pre-pass hardware present; 0 = MODE ignored and K_I is always treated as the round-10 key.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ST  in  1  start request; sampled only in IDLE.
- MODE  in  1  0 = K_I is the round-10 key; 1 = K_I is the cipher key.
- K_I  in  128  input key; W0 = [127:96], W3 = [31:0].
- RK_RDY  in  1  consumer ready for the current round key.
- RK_O  out  128  current round key.
- RK_IDX  out  4  round number of RK_O, 10..0.
- RK_VLD  out  1  RK_O and RK_IDX are valid.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse after the round-0 key is accepted.

Behaviour:
- Reset (asynchronous, RST_N = 0): state = IDLE; key register, RK_O = 0; RK_IDX = 0; RK_VLD = 0; BUSY = 0; DONE = 0; round counter = 0.
- g(W) = SubWord(RotWord(W)) ^ RCON.
  - RotWord = {W[23:0], W[31:24]}.
  - SubWord applies the AES S-box per byte.
  - RCON = {rc, 24'h0}.
  - rc for rounds 1..10 = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - rc comes from an internal table indexed by round counter; no external RCON input.
- Forward step, producing round i from round i-1:
  - W4 = W0 ^ g(W3), using rc(i).
  - W5 = W4 ^ W1; W6 = W5 ^ W2; W7 = W6 ^ W3.
- Inverse step, producing round i-1 from round i; the key register holds W4..W7:
  - W3' = W7 ^ W6; W2' = W6 ^ W5; W1' = W5 ^ W4.
  - W0' = W4 ^ g(W3'), using rc(i).
- Each step is single-cycle combinational from the key register. The S-box is combinational and shared between forward and inverse steps (one 4-byte SubWord instance).
- States:
  - IDLE: ST = 1 loads K_I into the key register.
    - If MODE = 1 and FWD_EN = 1: counter = 1, go to FWD.
    - Otherwise: counter = 10, go to OUT.
  - FWD: one forward step per cycle, counter increments. After the step for round 10 (10 cycles total), set counter = 10 and go to OUT. RK_VLD = 0 throughout.
  - OUT: RK_VLD = 1, RK_O = key register, RK_IDX = counter.
    - Transfer occurs when RK_VLD & RK_RDY.
    - On transfer with counter > 0: key register becomes the inverse-step result, counter decrements, RK_VLD stays 1. Back-to-back transfers are allowed, one per cycle.
    - On transfer with counter = 0: go to DONE.
    - While RK_RDY = 0: RK_O and RK_IDX hold stable.
  - DONE: DONE = 1 and RK_VLD = 0 for one cycle, then IDLE.
- Latency:
  - MODE = 0: first RK_VLD in the cycle after ST is sampled.
  - MODE = 1: first RK_VLD 11 cycles after ST is sampled.
  - Full sweep with RK_RDY held high: 11 valid cycles.
- ST while BUSY = 1 is ignored; K_I and MODE are not re-sampled.
- K_I and MODE are sampled only on the ST cycle; later changes have no effect.
- RST_N asserted mid-FWD or mid-OUT: immediate return to reset values; no DONE pulse.
- RK_RDY high while RK_VLD = 0: no effect.
- ST in the DONE cycle is ignored; the earliest restart is the following IDLE cycle.

Test Plan:
- MODE = 1, K_I = 2b7e151628aed2a6abf7158809cf4f3c, RK_RDY = 1 -> after 11 cycles RK_O = d014f9a8c9ee2589e13f0cc8b6630ca6 with IDX 10; next cycle ac7766f319fadc2128d12941575c006e with IDX 9; ...; IDX 1 = a0fafe1788542cb123a339392a6c7605; IDX 0 = 2b7e1516...4f3c; then a DONE pulse.
- MODE = 0, K_I = d014f9a8c9ee2589e13f0cc8b6630ca6 -> RK_VLD in the next cycle; same 11-key sequence as above, ending at 2b7e1516...4f3c.
- Backpressure: RK_RDY toggled 0/1 at random -> RK_O and RK_IDX stable while RK_RDY = 0; no key skipped or duplicated; all 11 keys match the golden sequence.
- ST pulsed during FWD and during OUT with a different K_I -> ignored; output sequence unchanged.
- RST_N pulled low at IDX 5 -> all outputs 0 asynchronously, no DONE; a fresh ST then produces the full correct sequence.
- Consecutive runs: ST asserted in the first IDLE cycle after DONE -> second sweep is correct; BUSY is low for exactly one cycle between runs.
